// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC, credit-gated imem requests, tagged instruction FIFO
module ifetch #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [63:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [63:0] o_instr_pc,
    output logic        o_instr_err,
    input  logic        i_instr_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_WIDE = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(FIFO_DEPTH - 1);

    logic [63:0]   pc;
    logic [63:0]   rsp_pc;
    logic [63:0]   redirect_target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] count;
    logic [CW-1:0] discard;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW:0]   inflight;

    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [63:0]   fifo_pc    [FIFO_DEPTH];
    logic          fifo_err   [FIFO_DEPTH];

    logic grant;
    logic pop_raw;
    logic pop;
    logic drop;
    logic push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign redirect_target = i_redirect_pc & ~64'h3;

    // Handshake decode and credit check; a pop in this cycle frees its slot for a new request.
    always_comb begin
        pop_raw     = o_instr_valid && i_instr_ready;
        pop         = pop_raw && !i_redirect;
        drop        = i_imem_rvalid && (i_redirect || (discard != '0));
        push        = i_imem_rvalid && !drop;
        inflight    = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop_raw};
        o_imem_req  = !i_rst && !i_redirect && (inflight < DEPTH_WIDE);
        o_imem_addr = pc;
        grant       = o_imem_req && i_imem_gnt;
    end

    // Head of FIFO drives decode; payload reads as zero whenever nothing is buffered.
    always_comb begin
        o_instr_valid = (count != '0);
        o_instr       = '0;
        o_instr_pc    = '0;
        o_instr_err   = 1'b0;
        if (o_instr_valid) begin
            o_instr     = fifo_instr[rd_ptr];
            o_instr_pc  = fifo_pc[rd_ptr];
            o_instr_err = fifo_err[rd_ptr];
        end
    end

    // Fetch PC and response PC; both restart together on redirect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc     <= RESET_PC;
            rsp_pc <= RESET_PC;
        end else if (i_redirect) begin
            pc     <= redirect_target;
            rsp_pc <= redirect_target;
        end else begin
            if (grant) pc <= pc + 64'd4;
            if (push)  rsp_pc <= rsp_pc + 64'd4;
        end
    end

    // Outstanding requests count every granted request until its response returns, stale or not.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            outstanding <= '0;
        end else if (grant && !i_imem_rvalid) begin
            outstanding <= outstanding + CW'(1);
        end else if (!grant && i_imem_rvalid) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    // Every unreturned response at redirect time is stale; one returning in the redirect cycle is dropped now.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            discard <= '0;
        end else if (i_redirect) begin
            discard <= outstanding - CW'(i_imem_rvalid);
        end else if (i_imem_rvalid && (discard != '0)) begin
            discard <= discard - CW'(1);
        end
    end

    // FIFO occupancy and pointers; redirect flushes ahead of any push or pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (i_redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Entry storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= i_imem_rdata;
            fifo_pc[wr_ptr]    <= rsp_pc;
            fifo_err[wr_ptr]   <= i_imem_err;
        end
    end

    // Credit gating must make a push into a full FIFO impossible unless the head leaves the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(push && !pop && (count == DEPTH_CNT)))
                else $error("ifetch fifo overflow");
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for ifetch
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_imem_err;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [63:0] o_instr_pc;
    logic        o_instr_err;
    logic        i_instr_ready;

    int errors = 0;
    int checks = 0;

    logic [63:0] q[$];
    bit          hold;
    bit          gnt_en;
    bit          ready_en;
    logic [63:0] err_addr;
    logic [63:0] exp_pc;
    logic [63:0] last_grant;
    logic [63:0] a_stall;
    logic [31:0] exp_word;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(64'h1000), .FIFO_DEPTH(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_imem_err    (i_imem_err),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .o_instr_err   (o_instr_err),
        .i_instr_ready (i_instr_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs for the coming edge; memory answers in order, one cycle or more after grant.
    task automatic drive(input bit redir, input logic [63:0] rpc);
        logic [63:0] a;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_imem_gnt    = gnt_en;
        i_instr_ready = ready_en;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        i_imem_err    = 1'b0;
        if (!hold && q.size() > 0) begin
            a = q.pop_front();
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = ~a[31:0];
            i_imem_err    = (a == err_addr);
        end
        #1;
    endtask

    // Record grants, score every accepted head entry, advance to the next falling edge.
    task automatic step();
        if (o_imem_req && i_imem_gnt) begin
            q.push_back(o_imem_addr);
            last_grant = o_imem_addr;
        end
        if (o_instr_valid && i_instr_ready && !i_redirect) begin
            exp_word = ~exp_pc[31:0];
            check("head_pc", o_instr_pc, exp_pc);
            check("head_instr", {32'h0, o_instr}, {32'h0, exp_word});
            check("head_err", {63'h0, o_instr_err}, {63'h0, (exp_pc == err_addr)});
            exp_pc = exp_pc + 64'd4;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        drive(1'b0, 64'h0);
        step();
    endtask

    task automatic wait_valid(input string tag, input logic [63:0] first_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive(1'b0, 64'h0);
            if (o_instr_valid) begin
                seen = 1'b1;
                check(tag, o_instr_pc, first_pc);
            end
            step();
        end
        check({tag, "_seen"}, {63'h0, seen}, 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; hold = 1'b0; gnt_en = 1'b1; ready_en = 1'b1;
        err_addr = 64'h1008; exp_pc = 64'h1000; last_grant = '0;
        i_redirect = 1'b0; i_redirect_pc = '0; i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_imem_err = 1'b0; i_instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        drive(1'b0, 64'h0);
        check("rst_req", {63'h0, o_imem_req}, 64'h0);
        check("rst_valid", {63'h0, o_instr_valid}, 64'h0);
        check("rst_instr", {32'h0, o_instr}, 64'h0);
        check("rst_pc", o_instr_pc, 64'h0);
        check("rst_err", {63'h0, o_instr_err}, 64'h0);
        rst = 1'b0;
        #1;

        // Streaming from reset, one fetch per cycle, head two cycles behind; error word at 0x1008.
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 64'h0);
            check("t1_req", {63'h0, o_imem_req}, 64'h1);
            check("t1_addr", o_imem_addr, 64'h1000 + 64'(4 * k));
            check("t1_valid", {63'h0, o_instr_valid}, {63'h0, (k >= 2)});
            if (k >= 2) check("t1_lag", o_instr_pc, 64'h1000 + 64'(4 * (k - 2)));
            step();
        end

        // Decode stalls: requests stop once credits are used, head held, nothing lost afterwards.
        ready_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 64'h0);
            check("t2_req", {63'h0, o_imem_req}, 64'h0);
            check("t2_valid", {63'h0, o_instr_valid}, 64'h1);
            check("t2_hold_pc", o_instr_pc, 64'h1018);
            check("t2_hold_instr", {32'h0, o_instr}, 64'h0000_0000_ffff_efe7);
            step();
        end
        ready_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 64'h0);
            check("t2_resume_valid", {63'h0, o_instr_valid}, 64'h1);
            check("t2_resume_pc", o_instr_pc, 64'h1018 + 64'(4 * k));
            step();
        end

        // Redirect with two requests outstanding and memory stalled.
        hold = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 64'h0);
            if (q.size() == 2 && !o_instr_valid) break;
            step();
        end
        check("t3_setup", {63'h0, (q.size() == 2 && !o_instr_valid)}, 64'h1);
        drive(1'b1, 64'h2002);
        check("t3_req_in_redirect", {63'h0, o_imem_req}, 64'h0);
        step();
        exp_pc = 64'h2000;
        drive(1'b0, 64'h0);
        check("t3_valid_after", {63'h0, o_instr_valid}, 64'h0);
        check("t3_addr", o_imem_addr, 64'h2000);
        step();
        hold = 1'b0;
        wait_valid("t3_first_pc", 64'h2000);

        // Redirect coinciding with a returning word and a pop.
        repeat (4) tick();
        drive(1'b1, 64'h3000);
        check("t4_setup_rvalid", {63'h0, i_imem_rvalid}, 64'h1);
        check("t4_setup_valid", {63'h0, o_instr_valid}, 64'h1);
        step();
        exp_pc = 64'h3000;
        drive(1'b0, 64'h0);
        check("t4_empty", {63'h0, o_instr_valid}, 64'h0);
        check("t4_req", {63'h0, o_imem_req}, 64'h1);
        check("t4_addr", o_imem_addr, 64'h3000);
        step();
        wait_valid("t4_first_pc", 64'h3000);

        // Grant withheld three cycles: address stable, then one grant advances it by exactly 4.
        repeat (2) tick();
        a_stall = last_grant + 64'd4;
        gnt_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 64'h0);
            check("t5_req", {63'h0, o_imem_req}, 64'h1);
            check("t5_addr_stable", o_imem_addr, a_stall);
            step();
        end
        gnt_en = 1'b1;
        drive(1'b0, 64'h0);
        check("t5_addr_grant", o_imem_addr, a_stall);
        step();
        drive(1'b0, 64'h0);
        check("t5_addr_next", o_imem_addr, a_stall + 64'd4);
        step();
        repeat (3) tick();

        // Reset mid-stream clears state at once and restarts from the reset PC.
        drive(1'b0, 64'h0);
        rst = 1'b1;
        #1;
        check("t7_rst_valid", {63'h0, o_instr_valid}, 64'h0);
        check("t7_rst_req", {63'h0, o_imem_req}, 64'h0);
        check("t7_rst_pc", o_instr_pc, 64'h0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 64'h1000;
        drive(1'b0, 64'h0);
        check("t7_addr", o_imem_addr, 64'h1000);
        check("t7_req", {63'h0, o_imem_req}, 64'h1);
        step();
        wait_valid("t7_first_pc", 64'h1000);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
